life_engine: RTL and testbench
==============================

Name: life_engine

Overview:
- Parametrised Game of Life engine with a W x H grid, holding all cell state in registers.
- Adds load, pause and single-step control, an internal step-rate divider, a generation counter, and a selectable edge mode (dead border or toroidal wrap).
- Detects still life and extinction, with optional auto-halt.
- Sits between board I/O (buttons, initial-pattern source) and the LED array driver, which consumes the flattened cell vector.

Parameters:
- W, 8, grid width in cells (>=3).
- H, 8, grid height in cells (>=3).
- STEP_PERIOD, 2**23, clk cycles between generations while running (>=1; 1 = every cycle).
- GEN_W, 16, width of generation counter.
- HALT_ON_STILL, 1, when 1, RUN enters HALT on still life/extinction.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wrap  in  1  edge mode: 0 = cells outside grid are dead, 1 = toroidal; sampled every evaluation
- load  in  1  pulse: load load_pattern into grid
- load_pattern  in  W*H  pattern; bit index W*y + x, (0,0) bottom-left
- run  in  1  level: 1 = free-run at STEP_PERIOD
- step  in  1  pulse: advance exactly one generation (IDLE only)
- cells  out  W*H  current grid, same indexing as load_pattern
- generation  out  GEN_W  generations since last load/reset
- step_done  out  1  one-cycle pulse, high in the cycle cells shows a new generation
- still  out  1  last evaluation found next == cells
- extinct  out  1  cells all zero
- halted  out  1  state == HALT

Behaviour:
- Single clock domain; rst_n is async-assert, sync-deassert via a 2-flop synchroniser inside.
- Reset values:
  - cells = 0, generation = 0.
  - step_done, still and halted = 0.
  - extinct = 1, because it is combinational from cells.
  - state = IDLE, divider = 0.
- Next-gen rule:
  - Neighbour count is 0..8 over the 8 neighbours, using 4-bit sums.
  - Alive next if count == 3, or if count == 2 and the cell is alive.
  - With wrap = 1, coordinates are taken modulo W/H.
  - With wrap = 0, out-of-range neighbours are 0.
- Advance event:
  - cells <= next, generation <= generation + 1 (wraps modulo 2**GEN_W), still <= (next == cells), step_done <= 1 in the same edge.
  - step_done = 0 on all other cycles.
- States:
  - IDLE:
    - step=1 -> advance, stay IDLE.
    - run=1 -> RUN, divider cleared.
  - RUN:
    - The divider counts 0..STEP_PERIOD-1.
    - At terminal count, the divider -> 0 and an evaluation occurs.
    - If HALT_ON_STILL and next == cells at evaluation: no generation increment and no step_done; still <= 1; -> HALT.
    - Otherwise advance.
    - run=0 -> IDLE, divider cleared; any evaluation due that same cycle is dropped.
    - step is ignored.
  - HALT:
    - cells and generation are frozen; step and run are ignored.
    - Exit only via load or reset.
- Load:
  - Highest priority, from any state.
  - cells <= load_pattern, generation <= 0, still <= 0, step_done <= 0.
  - Divider cleared; state <= IDLE.
  - load with run=1 held: IDLE -> RUN on the following cycle.
- Simultaneous load+step: load wins and step is discarded.
- extinct: combinational (cells == 0). With HALT_ON_STILL, an empty grid halts at its first RUN evaluation.
- Latency:
  - step sampled at edge k -> new cells visible after edge k.
  - First RUN advance occurs STEP_PERIOD cycles after entering RUN.
- Reset mid-operation returns everything to reset values immediately (async).

Decomposition:
- Package life_pkg:
  - state_t enum {IDLE, RUN, HALT}.
  - function cell_idx(x, y, W).
  - localparam NEIGH_W = 4.
- Sub-module life_next_gen(W, H):
  - Combinational: cells, wrap -> next.
  - Generate loop of per-cell 8-neighbour count and rule.
  - Lets the rule be verified standalone.
- life_engine holds the FSM, divider, counters and registers.

Test Plan:
- W=H=5, STEP_PERIOD=1, wrap=0, load horizontal blinker at row 2 (bits 11,12,13), run=1 -> cells alternates with the vertical blinker (bits 7,12,17) each cycle; generation increments 1,2,3...; still stays 0.
- W=H=8, wrap=1, load glider, run -> after 32 step_done pulses cells equals initial pattern; generation=32; never halts.
- Same glider, wrap=0, HALT_ON_STILL=1 -> settles to a 2x2 block in the corner; halted=1, still=1; generation frozen; step_done not asserted on the halting evaluation.
- IDLE, step pulse with blinker loaded -> exactly one advance, generation=1, one step_done; step while run=1 -> ignored.
- load asserted same cycle as step or an RUN terminal count -> cells=load_pattern, generation=0, state IDLE, no step_done.
- GEN_W=4, wrap=1 blinker, run for 17 gens -> generation reads 1 after wrap; rst_n low mid-RUN, asynchronously between edges -> cells=0, generation=0, halted=0 before next clk edge.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and helpers for the Game of Life engine.
// Cells are flattened row-major from the bottom-left corner.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int NEIGH_W = 4;

  function automatic int cell_idx(input int x, input int y, input int w);
    return w * y + x;
  endfunction

endpackage

// File: rtl/life_engine_if.sv
// Control/pattern bus between the board I/O side (master) and the engine (slave).
interface life_engine_if #(
  parameter int W     = 8,
  parameter int H     = 8,
  parameter int GEN_W = 16
);
  logic             wrap;
  logic             load;
  logic [W*H-1:0]   load_pattern;
  logic             run;
  logic             step;
  logic [W*H-1:0]   cells;
  logic [GEN_W-1:0] generation;
  logic             step_done;
  logic             still;
  logic             extinct;
  logic             halted;

  modport master (
    output wrap, load, load_pattern, run, step,
    input  cells, generation, step_done, still, extinct, halted
  );

  modport slave (
    input  wrap, load, load_pattern, run, step,
    output cells, generation, step_done, still, extinct, halted
  );
endinterface

// File: rtl/life_next_gen.sv
// Combinational next-generation evaluator: one 8-neighbour counter and rule per cell.
// i_wrap selects toroidal edges; otherwise cells outside the grid count as dead.
module life_next_gen
  import life_pkg::*;
#(
  parameter int W = 8,
  parameter int H = 8
) (
  input  logic [W*H-1:0] i_cells,
  input  logic           i_wrap,
  output logic [W*H-1:0] o_next
);

  for (genvar y = 0; y < H; y++) begin : g_row
    for (genvar x = 0; x < W; x++) begin : g_col
      logic [NEIGH_W-1:0] w_count;

      always_comb begin
        int   nx;
        int   ny;
        logic in_range;
        // NOTE: every variable gets a value before any conditional use, so no latch is inferred.
        w_count  = '0;
        nx       = 0;
        ny       = 0;
        in_range = 1'b0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            in_range = (x + dx >= 0) && (x + dx < W) && (y + dy >= 0) && (y + dy < H);
            nx       = (x + dx + W) % W;
            ny       = (y + dy + H) % H;
            if ((dx != 0 || dy != 0) && (i_wrap || in_range))
              w_count = w_count + NEIGH_W'(i_cells[cell_idx(nx, ny, W)]);
          end
        end
      end

      assign o_next[cell_idx(x, y, W)] = (w_count == NEIGH_W'(3)) ||
                                         ((w_count == NEIGH_W'(2)) && i_cells[cell_idx(x, y, W)]);
    end
  end

endmodule

// File: rtl/life_engine.sv
// Game of Life engine: load/step/run control, step-rate divider, generation counter
// and still-life/extinction detection with optional auto-halt.
module life_engine
  import life_pkg::*;
#(
  parameter int W             = 8,
  parameter int H             = 8,
  parameter int STEP_PERIOD   = 2**23,
  parameter int GEN_W         = 16,
  parameter int HALT_ON_STILL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  life_engine_if.slave bus
);

  localparam int N     = W * H;
  localparam int DIV_W = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [N-1:0]     r_cells;
  logic [N-1:0]     w_next;
  logic [GEN_W-1:0] r_gen;
  logic             r_step_done;
  logic             r_still;
  logic             w_advance;
  logic             w_halt_eval;
  logic             w_div_run;
  logic             w_div_tc;
  logic             w_same;

  // Reset asserts immediately but releases two clean edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  life_next_gen #(.W(W), .H(H)) u_next_gen (
    .i_cells (r_cells),
    .i_wrap  (bus.wrap),
    .o_next  (w_next)
  );

  assign w_same   = (w_next == r_cells);
  assign w_div_tc = (r_div == DIV_W'(STEP_PERIOD - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_advance   = 1'b0;
    w_halt_eval = 1'b0;
    w_div_run   = 1'b0;
    if (bus.load) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.step)     w_advance   = 1'b1;
          else if (bus.run) w_state_nxt = RUN;
        end
        RUN: begin
          // Dropping run cancels any evaluation that was due this cycle.
          if (!bus.run) begin
            w_state_nxt = IDLE;
          end else begin
            w_div_run = 1'b1;
            if (w_div_tc) begin
              if ((HALT_ON_STILL != 0) && w_same) begin
                w_halt_eval = 1'b1;
                w_state_nxt = HALT;
              end else begin
                w_advance = 1'b1;
              end
            end
          end
        end
        HALT:    w_state_nxt = HALT;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: all sequential state uses non-blocking assignments so each flop samples pre-edge values.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_div       <= '0;
      r_cells     <= '0;
      r_gen       <= '0;
      r_step_done <= 1'b0;
      r_still     <= 1'b0;
    end else begin
      r_div       <= (w_div_run && !w_div_tc) ? r_div + 1'b1 : '0;
      r_step_done <= w_advance;
      if (bus.load) begin
        r_cells <= bus.load_pattern;
        r_gen   <= '0;
        r_still <= 1'b0;
      end else if (w_advance) begin
        r_cells <= w_next;
        r_gen   <= r_gen + 1'b1;
        r_still <= w_same;
      end else if (w_halt_eval) begin
        r_still <= 1'b1;
      end
    end
  end

  assign bus.cells      = r_cells;
  assign bus.generation = r_gen;
  assign bus.step_done  = r_step_done;
  assign bus.still      = r_still;
  assign bus.extinct    = ~|r_cells;
  assign bus.halted     = (r_state == HALT);

endmodule

// File: tb/tb_life_engine.sv
// Self-checking bench: directed scenarios plus random control traffic, every cycle
// compared against a behavioural Life model and a countdown-based control model.
module tb_life_engine;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int N  = W * H;
  localparam int SP = 3;
  localparam int GW = 4;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  life_engine_if #(.W(W), .H(H), .GEN_W(GW)) bus ();

  life_engine #(
    .W(W), .H(H), .STEP_PERIOD(SP), .GEN_W(GW), .HALT_ON_STILL(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  logic [N-1:0] m_cells;
  int           m_gen;
  logic         m_step_done;
  logic         m_still;
  int           m_mode;
  int           m_countdown;
  int           m_sync;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [N-1:0] put(input logic [N-1:0] g, input int x, input int y);
    logic [N-1:0] r;
    r = g;
    r[y * W + x] = 1'b1;
    return r;
  endfunction

  // Direct reading of the Life rules over a 2-D grid.
  function automatic logic [N-1:0] life(input logic [N-1:0] g, input logic wr);
    logic [N-1:0] r;
    int n, xx, yy;
    r = '0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            xx = x + dx;
            yy = y + dy;
            if (wr) begin
              xx = (xx + W) % W;
              yy = (yy + H) % H;
            end
            if ((dx != 0 || dy != 0) && xx >= 0 && xx < W && yy >= 0 && yy < H)
              n += int'(g[yy * W + xx]);
          end
        end
        r[y * W + x] = (n == 3) || (n == 2 && g[y * W + x]);
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_cells     = '0;
    m_gen       = 0;
    m_step_done = 1'b0;
    m_still     = 1'b0;
    m_mode      = M_IDLE;
    m_countdown = 0;
    m_sync      = 0;
  endtask

  task automatic model_advance(input logic [N-1:0] nx);
    m_still     = (nx == m_cells);
    m_cells     = nx;
    m_gen       = (m_gen + 1) % (1 << GW);
    m_step_done = 1'b1;
  endtask

  task automatic model_edge();
    logic [N-1:0] nx;
    m_step_done = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_sync < 2) begin
      m_sync++;
      return;
    end
    nx = life(m_cells, bus.wrap);
    if (bus.load) begin
      m_cells = bus.load_pattern;
      m_gen   = 0;
      m_still = 1'b0;
      m_mode  = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      if (bus.step) model_advance(nx);
      else if (bus.run) begin
        m_mode      = M_RUN;
        m_countdown = SP;
      end
    end else if (m_mode == M_RUN) begin
      if (!bus.run) m_mode = M_IDLE;
      else begin
        m_countdown--;
        if (m_countdown == 0) begin
          m_countdown = SP;
          if (nx == m_cells) begin
            m_still = 1'b1;
            m_mode  = M_HALT;
          end else begin
            model_advance(nx);
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (bus.step_done) done_cnt++;
    check("cells",      64'(bus.cells),      64'(m_cells));
    check("generation", 64'(bus.generation), 64'(m_gen));
    check("step_done",  64'(bus.step_done),  64'(m_step_done));
    check("still",      64'(bus.still),      64'(m_still));
    check("extinct",    64'(bus.extinct),    64'(m_cells == '0));
    check("halted",     64'(bus.halted),     64'(m_mode == M_HALT));
  endtask

  task automatic do_load(input logic [N-1:0] p);
    bus.load_pattern = p;
    bus.load         = 1'b1;
    tick();
    bus.load         = 1'b0;
  endtask

  task automatic pulse_step();
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
  endtask

  logic [N-1:0] blinker_h, blinker_v, glider, block;

  initial begin
    blinker_h = put(put(put('0, 2, 3), 3, 3), 4, 3);
    blinker_v = put(put(put('0, 3, 2), 3, 3), 3, 4);
    glider    = put(put(put(put(put('0, 4, 5), 5, 4), 3, 3), 4, 3), 5, 3);
    block     = put(put(put(put('0, 0, 0), 1, 0), 0, 1), 1, 1);

    bus.wrap = 1'b0; bus.load = 1'b0; bus.load_pattern = '0;
    bus.run  = 1'b0; bus.step = 1'b0;
    model_reset();

    #1 rst_n = 1'b0;
    #2;
    check("rst_cells",     64'(bus.cells),      64'd0);
    check("rst_gen",       64'(bus.generation), 64'd0);
    check("rst_extinct",   64'(bus.extinct),    64'd1);
    check("rst_halted",    64'(bus.halted),     64'd0);
    check("rst_step_done", 64'(bus.step_done),  64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Single steps from IDLE on a dead-border blinker.
    do_load(blinker_h);
    tick();
    pulse_step();
    check("step1_cells", 64'(bus.cells),      64'(blinker_v));
    check("step1_gen",   64'(bus.generation), 64'd1);
    tick();
    pulse_step();
    check("step2_cells", 64'(bus.cells),      64'(blinker_h));
    check("step2_gen",   64'(bus.generation), 64'd2);

    // step is ignored while running (dropping run before the first evaluation).
    bus.run = 1'b1;
    tick();
    pulse_step();
    bus.run = 1'b0;
    tick();
    check("run_step_ignored", 64'(bus.generation), 64'd2);

    // load beats a simultaneous step.
    bus.step = 1'b1;
    do_load(glider);
    bus.step = 1'b0;
    check("load_step_cells", 64'(bus.cells),      64'(glider));
    check("load_step_gen",   64'(bus.generation), 64'd0);
    check("load_step_done",  64'(bus.step_done),  64'd0);

    // load beats a RUN terminal count; run held re-enters RUN afterwards.
    bus.run = 1'b1;
    repeat (SP) tick();
    do_load(blinker_h);
    check("load_tc_cells", 64'(bus.cells),      64'(blinker_h));
    check("load_tc_gen",   64'(bus.generation), 64'd0);
    check("load_tc_done",  64'(bus.step_done),  64'd0);

    // Generation counter wraps modulo 2**GW on a toroidal blinker.
    bus.wrap = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 17 * SP + 10 && done_cnt < 17; i++) tick();
    check("gen_wrap_pulses", 64'(done_cnt),       64'd17);
    check("gen_wrap_value",  64'(bus.generation), 64'd1);

    // Asynchronous reset in the middle of a cycle while running.
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_cells",  64'(bus.cells),      64'd0);
    check("async_rst_gen",    64'(bus.generation), 64'd0);
    check("async_rst_halted", 64'(bus.halted),     64'd0);
    model_reset();
    bus.run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();

    // Glider on the torus returns to its start after 32 generations.
    bus.wrap = 1'b1;
    do_load(glider);
    bus.run  = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 32 * SP + 20 && done_cnt < 32; i++) tick();
    check("torus_pulses", 64'(done_cnt),       64'd32);
    check("torus_cells",  64'(bus.cells),      64'(glider));
    check("torus_gen",    64'(bus.generation), 64'd0);
    check("torus_halted", 64'(bus.halted),     64'd0);

    // Same glider against dead borders.
    bus.wrap = 1'b0;
    do_load(glider);
    repeat (300) tick();

    // A block halts at its first evaluation and then stays frozen.
    bus.run = 1'b0;
    do_load(block);
    bus.run = 1'b1;
    for (int i = 0; i < 20 && !bus.halted; i++) tick();
    check("block_halted", 64'(bus.halted),     64'd1);
    check("block_still",  64'(bus.still),      64'd1);
    check("block_gen",    64'(bus.generation), 64'd0);
    pulse_step();
    repeat (2 * SP) tick();
    check("halt_frozen_gen",   64'(bus.generation), 64'd0);
    check("halt_frozen_cells", 64'(bus.cells),      64'(block));

    // An empty grid halts as well.
    do_load('0);
    for (int i = 0; i < 20 && !bus.halted; i++) tick();
    check("empty_halted", 64'(bus.halted), 64'd1);

    // Random control traffic.
    for (int i = 0; i < 1500; i++) begin
      bus.load = ($urandom_range(0, 39) == 0);
      if (bus.load) bus.load_pattern = {$urandom, $urandom} & {$urandom, $urandom};
      bus.step = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 29) == 0) bus.run = ~bus.run;
      if ($urandom_range(0, 49) == 0) bus.wrap = ~bus.wrap;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
